// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module one_bit_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] res_sh;

    one_bit_adder u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .ci  (c_q),
        .sum (fa_s),
        .co  (fa_co)
    );

    // Result register with the current sum bit entering at the MSB
    if (WIDTH == 1) begin : g_w1
        assign res_sh = fa_s;
    end else begin : g_wn
        assign res_sh = {fa_s, res_q[WIDTH-1:1]};
    end

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last   = (state_q == S_RUN) && (cnt_q == LAST);

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

    // Next-state: sequencing, operand shifting and result capture
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            a_sr_d = a;
            b_sr_d = b;
            res_d  = '0;
            cnt_d  = '0;
            c_d    = ci;
        end else if (state_q == S_RUN) begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            res_d  = res_sh;
            cnt_d  = cnt_q + CW'(1);
            c_d    = fa_co;
            if (last) begin
                sum_d = res_sh;
                co_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // carry into the MSB is the carry FF during the last bit
                ovf_d = c_q ^ fa_co;
`endif
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder (WIDTH=8)
// against an arithmetic reference model {co,sum} = a + b + ci.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       co;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic c);
        start = 1'b1;
        a     = x;
        b     = y;
        ci    = c;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        ci    = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        ci    = 1'b0;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co: got %b want 0", co); end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        launch(8'h0F, 8'h01, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy c%0d: got %b want 1", k, busy); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done c%0d: got %b want 0", k, done); end
            n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL basic_sum_hold c%0d: got %h want 00", k, sum); end
            tick();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL basic_sum: got %h want 10", sum); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL basic_co: got %b want 0", co); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL basic_sum_keep: got %h want 10", sum); end
    endtask

    task automatic test_carry_ovf();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vc [4];
        logic [7:0] es [4];
        logic       ec [4];
        logic       eo [4];
        va = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
        vb = '{8'h01, 8'hFF, 8'h01, 8'h80};
        vc = '{1'b0, 1'b1, 1'b0, 1'b0};
        es = '{8'h00, 8'hFF, 8'h80, 8'h00};
        ec = '{1'b1, 1'b1, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vc[i]);
            repeat (7) tick();
            tick();
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL carry_done v%0d: got %b want 1", i, done); end
            n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL carry_sum v%0d: got %h want %h", i, sum, es[i]); end
            n_checks++; if (co !== ec[i]) begin n_fail++; $display("FAIL carry_co v%0d: got %b want %b", i, co, ec[i]); end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL ovf v%0d: got %b want %b", i, ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("unexpected table value");
`endif
            tick();
        end
    endtask

    task automatic test_ignored_start();
        launch(8'h0F, 8'h01, 1'b0);
        tick();
        tick();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        ci    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 3; k < 8; k++) begin
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ign_early_done c%0d: got %b want 0", k, done); end
            tick();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b want 1", done); end
        n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL ign_sum: got %h want 10", sum); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL ign_co: got %b want 0", co); end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ign_extra_done t%0d: got %b want 0", k, done); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_busy t%0d: got %b want 0", k, busy); end
        end
    endtask

    task automatic test_back_to_back();
        launch(8'h0F, 8'h01, 1'b0);
        repeat (8) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", done); end
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        ci    = 1'b0;
        n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL b2b_sum1: got %h want 10", sum); end
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", busy); end
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL b2b_sum_hold c%0d: got %h want 10", k, sum); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done c%0d: got %b want 0", k, done); end
            tick();
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want 1", k, busy); end
        end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", done); end
        n_checks++; if (sum !== 8'h03) begin n_fail++; $display("FAIL b2b_sum2: got %h want 03", sum); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL b2b_co2: got %b want 0", co); end
        tick();
    endtask

    task automatic test_reset_mid();
        launch(8'hC3, 8'h5A, 1'b1);
        repeat (4) tick();
        #4;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL rmid_sum: got %h want 00", sum); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL rmid_co: got %b want 0", co); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++; if (done !== 1'b0 || sum !== 8'h00) begin
                n_fail++; $display("FAIL rmid_stale c%0d: done %b sum %h want 0 00", k, done, sum);
            end
        end
        launch(8'hC3, 8'h5A, 1'b1);
        repeat (8) tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmid_fresh_done: got %b want 1", done); end
        n_checks++; if (sum !== 8'h1E) begin n_fail++; $display("FAIL rmid_fresh_sum: got %h want 1e", sum); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL rmid_fresh_co: got %b want 1", co); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp;
        logic [8:0] prev;
        int         lat;
        prev = 9'h11E;
        for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            launch(ra, rb, rc);
            lat = 0;
            while (done !== 1'b1 && lat < 20) begin
                n_checks++; if (busy !== 1'b1 || {co, sum} !== prev) begin
                    n_fail++; $display("FAIL rnd_run n%0d c%0d: busy %b res %h want 1 %h", n, lat, busy, {co, sum}, prev);
                end
                start = ($urandom_range(0, 3) == 0);
                a     = 8'($urandom);
                tick();
                lat++;
            end
            start = 1'b0;
            n_checks++; if (lat != 8) begin n_fail++; $display("FAIL rnd_latency n%0d: got %0d want 8", n, lat); end
            n_checks++; if ({co, sum} !== exp) begin
                n_fail++; $display("FAIL rnd_result n%0d: %h+%h+%b got %h want %h", n, ra, rb, rc, {co, sum}, exp);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++; if (ovf !== ((ra[7] == rb[7]) && (exp[7] != ra[7]))) begin
                n_fail++; $display("FAIL rnd_ovf n%0d: got %b", n, ovf);
            end
`endif
            prev = exp;
            if ($urandom_range(0, 1) == 1) begin
                tick();
                n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_idle n%0d: done %b busy %b want 0 0", n, done, busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ovf();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
